split_solution_sampler: RTL

Active counterpart to the combinational split constraint checkers. Each checker consumes a packed set of variable fields and returns a 1-bit satisfied flag `x`; this block produces those assignments. It generates pseudo-random candidate vectors from a seeded LFSR and presents them to an external checker. It then samples the verdict and streams satisfying assignments out over a valid/ready handshake, giving up after a bounded number of tries.

---
 rtl/split_sampler_pkg.sv | 29 ++
 rtl/split_lfsr32.sv | 24 ++
 rtl/split_solution_sampler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/split_sampler_pkg.sv
// Shared constants, FSM state encoding and the LFSR step function for the
// split-constraint solution sampler.
package split_sampler_pkg;

    localparam int unsigned LFSR_W    = 32;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FILL = 3'd1;
    localparam state_t ST_EVAL = 3'd2;
    localparam state_t ST_EMIT = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_FAIL = 3'd5;

    // One Galois step: shift right, fold the mask back in when a 1 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] word);
        logic [LFSR_W-1:0] nxt;
        nxt = {1'b0, word[LFSR_W-1:1]};
        if (word[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/split_lfsr32.sv
// 32-bit Galois LFSR with seed load, zero-seed guard and enable-gated stepping.
module split_lfsr32
    import split_sampler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] word
);

    // Load has priority over step; an all-zero seed would lock the LFSR, so it becomes 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= 32'h0000_0001;
        end else if (load) begin
            word <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
        end else if (step) begin
            word <= lfsr_next(word);
        end
    end

endmodule

// File: rtl/split_solution_sampler.sv
// Generates pseudo-random candidate vectors, hands them to an external
// constraint checker and streams the satisfying ones out over valid/ready.
module split_solution_sampler
    import split_sampler_pkg::*;
#(
    parameter int unsigned VEC_W     = 224,
    parameter int unsigned MAX_TRIES = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_sol,
    output logic [VEC_W-1:0] cand,
    output logic             cand_vld,
    input  logic             verdict,
    input  logic             verdict_vld,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [VEC_W-1:0] sol_data,
    output logic [CNT_W-1:0] tries,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    localparam int unsigned      NUM_WORDS  = VEC_W / LFSR_W;
    localparam int unsigned      FILL_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [FILL_W-1:0] LAST_WORD = FILL_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] TRIES_MAX  = CNT_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] TRIES_LAST = CNT_W'(MAX_TRIES - 1);

    state_t              state_r;
    logic [FILL_W-1:0]   fill_idx_r;
    logic [CNT_W-1:0]    sol_cnt_r;
    logic [CNT_W-1:0]    num_sol_r;
    logic [CNT_W-1:0]    sol_cnt_inc_s;
    logic [LFSR_W-1:0]   lfsr_word_s;
    logic                lfsr_load_s;
    logic                lfsr_step_s;

    split_lfsr32 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load_s),
        .seed (seed),
        .step (lfsr_step_s),
        .word (lfsr_word_s)
    );

    // LFSR seeds only on an accepted start and steps only while filling.
    always_comb begin
        lfsr_load_s   = 1'b0;
        lfsr_step_s   = 1'b0;
        sol_cnt_inc_s = sol_cnt_r + CNT_W'(1);
        if (state_r == ST_IDLE) begin
            lfsr_load_s = start;
        end else begin
            lfsr_load_s = 1'b0;
        end
        if (state_r == ST_FILL) begin
            lfsr_step_s = 1'b1;
        end else begin
            lfsr_step_s = 1'b0;
        end
    end

    // Run controller: fill, evaluate, emit; done/fail are raised on the edge entering DONE/FAIL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fill_idx_r <= {FILL_W{1'b0}};
            sol_cnt_r  <= {CNT_W{1'b0}};
            num_sol_r  <= {CNT_W{1'b0}};
            cand       <= {VEC_W{1'b0}};
            cand_vld   <= 1'b0;
            sol_valid  <= 1'b0;
            sol_data   <= {VEC_W{1'b0}};
            tries      <= {CNT_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_sol_r  <= (num_sol == {CNT_W{1'b0}}) ? CNT_W'(1) : num_sol;
                        tries      <= {CNT_W{1'b0}};
                        sol_cnt_r  <= {CNT_W{1'b0}};
                        fill_idx_r <= {FILL_W{1'b0}};
                        busy       <= 1'b1;
                        state_r    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cand[fill_idx_r*LFSR_W +: LFSR_W] <= lfsr_word_s;
                    if (fill_idx_r == LAST_WORD) begin
                        fill_idx_r <= {FILL_W{1'b0}};
                        cand_vld   <= 1'b1;
                        state_r    <= ST_EVAL;
                    end else begin
                        fill_idx_r <= fill_idx_r + FILL_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (verdict_vld) begin
                        if (tries != TRIES_MAX) begin
                            tries <= tries + CNT_W'(1);
                        end
                        cand_vld <= 1'b0;
                        if (verdict) begin
                            sol_data  <= cand;
                            sol_valid <= 1'b1;
                            state_r   <= ST_EMIT;
                        end else if (tries == TRIES_LAST) begin
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_FAIL;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                ST_EMIT: begin
                    if (sol_valid && sol_ready) begin
                        sol_valid <= 1'b0;
                        sol_cnt_r <= sol_cnt_inc_s;
                        if (sol_cnt_inc_s == num_sol_r) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_DONE;
                        end else if (tries == TRIES_MAX) begin
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_FAIL;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_FAIL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    cand_vld  <= 1'b0;
                    sol_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
